// File: rtl/dmem_responder_if.sv
// Load/store bus between the datapath (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int NBITS = 8
);
    logic             Req;
    logic             MemWrite;
    logic [NBITS-1:2] Address;
    logic [NBITS-1:0] WriteData;
    logic [NBITS-1:0] ReadData;
    logic             Ready;
    logic             Busy;

    modport master (output Req, MemWrite, Address, WriteData,
                    input  ReadData, Ready, Busy);
    modport slave  (input  Req, MemWrite, Address, WriteData,
                    output ReadData, Ready, Busy);
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with LATENCY wait states behind a Req/Ready handshake.
// Defining DMEM_OVERLAP_ERR_EN adds a sticky OverlapErr flag for requests made while busy.
module dmem_responder #(
    parameter int NBITS   = 8,
    parameter int NWORDS  = 2**(NBITS-2),
    parameter int LATENCY = 2
) (
    input  logic clock,
    input  logic reset,
`ifdef DMEM_OVERLAP_ERR_EN
    output logic OverlapErr,
`endif
    dmem_responder_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [NBITS-1:2] addr_q, addr_d;
    logic [NBITS-1:0] wdata_q, wdata_d;
    logic [NBITS-1:0] rdata_q, rdata_d;
    logic             we_q, we_d;
    logic             access;

    // Array is deliberately left out of reset so an aborted store cannot disturb it.
    logic [NBITS-1:0] mem_q [NWORDS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Req) begin
                    addr_d  = bus.Address;
                    wdata_d = bus.WriteData;
                    we_d    = bus.MemWrite;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    if (!we_q) rdata_d = mem_q[addr_q];
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (access && we_q) mem_q[addr_q] <= wdata_q;
    end

    assign bus.ReadData = rdata_q;
    assign bus.Ready    = (state_q == S_DONE);
    assign bus.Busy     = (state_q != S_IDLE);

`ifdef DMEM_OVERLAP_ERR_EN
    logic ovl_q, ovl_d;

    always_comb ovl_d = ovl_q | (bus.Req && (state_q != S_IDLE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ovl_q <= 1'b0;
        else       ovl_q <= ovl_d;
    end

    assign OverlapErr = ovl_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table-driven requests checked through a completion scoreboard,
// plus hand sequences for held Req, reset mid-access and a LATENCY=1 instance.
module tb_dmem_responder;
  localparam int NBITS = 8;
  localparam int LAT   = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_responder_if #(.NBITS(NBITS)) bus  ();
  dmem_responder_if #(.NBITS(NBITS)) bus1 ();
`ifdef DMEM_OVERLAP_ERR_EN
  logic ovl, ovl1;
`endif

  dmem_responder #(.NBITS(NBITS), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
`ifdef DMEM_OVERLAP_ERR_EN
    .OverlapErr(ovl),
`endif
    .bus(bus.slave));

  dmem_responder #(.NBITS(NBITS), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset),
`ifdef DMEM_OVERLAP_ERR_EN
    .OverlapErr(ovl1),
`endif
    .bus(bus1.slave));

  typedef struct {
    logic       mw;
    logic [5:0] addr;
    logic [7:0] wd;
    logic [7:0] rd;
  } vec_t;

  typedef struct {
    logic       ld;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  vec_t       tbl[8];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  logic [7:0] last_rd = 8'h00;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completion monitor for the LATENCY=2 instance
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (!reset && bus.Ready) begin
      if (sbq.size() == 0) begin
        check("spurious_ready", 32'(bus.Ready), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("ready_cycle", 32'(cyc), 32'(e.due));
        if (e.ld) check("load_rdata", 32'(bus.ReadData), 32'(e.data));
        else      check("store_keeps_rdata", 32'(bus.ReadData), 32'(e.data));
      end
    end
  end

  task automatic push_exp(input logic mw, input logic [7:0] rd);
    exp_t e;
    if (!mw) last_rd = rd;
    e.ld   = !mw;
    e.data = last_rd;
    e.due  = cyc + LAT;
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      if (!bus.Busy) begin ok = 1'b1; break; end
    end
    check("idle_within_bound", 32'(ok), 32'd1);
    check("rdata_held", 32'(bus.ReadData), 32'(last_rd));
  endtask

  task automatic do_req(input logic mw, input logic [5:0] a, input logic [7:0] wd, input logic [7:0] rd);
    @(negedge clock);
    bus.Req = 1'b1; bus.MemWrite = mw; bus.Address = a; bus.WriteData = wd;
    @(posedge clock); #1;
    check("busy_after_accept", 32'(bus.Busy), 32'd1);
    push_exp(mw, rd);
    // Scramble inputs so only the latched copies can be used
    bus.Req = 1'b0; bus.Address = ~a; bus.WriteData = ~wd; bus.MemWrite = ~mw;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 6'd5,  8'hA5, 8'h00};
    tbl[1] = '{1'b0, 6'd5,  8'h00, 8'hA5};
    tbl[2] = '{1'b1, 6'd63, 8'h3C, 8'h00};
    tbl[3] = '{1'b1, 6'd0,  8'h11, 8'h00};
    tbl[4] = '{1'b0, 6'd63, 8'h00, 8'h3C};
    tbl[5] = '{1'b0, 6'd0,  8'h00, 8'h11};
    tbl[6] = '{1'b1, 6'd5,  8'h5A, 8'h00};
    tbl[7] = '{1'b0, 6'd5,  8'h00, 8'h5A};

    reset = 1'b1;
    bus.Req = 1'b0;  bus.MemWrite = 1'b0;  bus.Address = '0;  bus.WriteData = '0;
    bus1.Req = 1'b0; bus1.MemWrite = 1'b0; bus1.Address = '0; bus1.WriteData = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_ready", 32'(bus.Ready), 32'd0);
    check("rst_rdata", 32'(bus.ReadData), 32'd0);
`ifdef DMEM_OVERLAP_ERR_EN
    check("rst_ovl", 32'(ovl), 32'd0);
`endif

    for (int i = 0; i < 8; i++) do_req(tbl[i].mw, tbl[i].addr, tbl[i].wd, tbl[i].rd);

    // Req held high for 10 cycles: acceptances at i = 0, 4, 8
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.Req = 1'b1; bus.MemWrite = 1'b1; bus.Address = 6'(20 + i); bus.WriteData = 8'(8'h80 + i);
      @(posedge clock); #1;
      if (i % 4 == 0) push_exp(1'b1, 8'h00);
      check("held_busy", 32'(bus.Busy), 32'((i % 4) != 3));
`ifdef DMEM_OVERLAP_ERR_EN
      check("held_ovl", 32'(ovl), 32'(i >= 1));
`endif
    end
    @(negedge clock);
    bus.Req = 1'b0;
    wait_idle();
    do_req(1'b0, 6'd20, 8'h00, 8'h80);
    do_req(1'b0, 6'd24, 8'h00, 8'h84);
    do_req(1'b0, 6'd28, 8'h00, 8'h88);

    // Reset during WAIT discards the pending store
    do_req(1'b1, 6'd7, 8'h42, 8'h00);
    @(negedge clock);
    bus.Req = 1'b1; bus.MemWrite = 1'b1; bus.Address = 6'd7; bus.WriteData = 8'hFF;
    @(posedge clock); #1;
    bus.Req = 1'b0;
    check("abort_busy_pre", 32'(bus.Busy), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy_async", 32'(bus.Busy), 32'd0);
    check("abort_ready_async", 32'(bus.Ready), 32'd0);
    check("abort_rdata_async", 32'(bus.ReadData), 32'd0);
`ifdef DMEM_OVERLAP_ERR_EN
    check("abort_ovl_clr", 32'(ovl), 32'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
    last_rd = 8'h00;
    @(posedge clock); #1;
    check("abort_no_ready", 32'(bus.Ready), 32'd0);
    do_req(1'b0, 6'd7, 8'h00, 8'h42);

    // LATENCY=1 instance: store then load word 9
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      bus1.Req = 1'b1; bus1.MemWrite = (j == 0); bus1.Address = 6'd9; bus1.WriteData = 8'h33;
      @(posedge clock); #1;
      bus1.Req = 1'b0; bus1.WriteData = 8'h00; bus1.Address = 6'd1;
      check("l1_busy_e0", 32'(bus1.Busy), 32'd1);
      check("l1_ready_e0", 32'(bus1.Ready), 32'd0);
      @(posedge clock); #1;
      check("l1_ready_e1", 32'(bus1.Ready), 32'd1);
      check("l1_busy_e1", 32'(bus1.Busy), 32'd1);
      if (j == 1) check("l1_rdata", 32'(bus1.ReadData), 32'h33);
      @(posedge clock); #1;
      check("l1_busy_e2", 32'(bus1.Busy), 32'd0);
      check("l1_ready_e2", 32'(bus1.Ready), 32'd0);
    end
`ifdef DMEM_OVERLAP_ERR_EN
    check("l1_ovl", 32'(ovl1), 32'd0);
`endif

    repeat (2) @(posedge clock);
    #1;
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
